// File: rtl/ula_bus_reader_if.sv
// Handshake and bus bundle between the ULA control path, the result-bus reader
// and the bank of tri-state drivers it owns.
interface ula_bus_reader_if #(
    parameter int WIDTH = 9,
    parameter int NSRC  = 4,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
);
    logic             req_valid;
    logic [SELW-1:0]  req_sel;
    logic             req_ready;
    logic [NSRC-1:0]  en;
    logic [WIDTH-1:0] bus;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-2:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_err;

    modport master (
        input  req_valid, req_sel, bus, res_ready,
        output req_ready, en, res_valid, res_data, res_carry, res_zero, res_err
    );

    modport slave (
        output req_valid, req_sel, res_ready,
        input  req_ready, en, bus, res_valid, res_data, res_carry, res_zero, res_err
    );
endinterface

// File: rtl/ula_bus_reader.sv
// Sequencing reader for the ULA's shared tri-state result bus: turnaround,
// single-driver enable, settle wait, capture, then valid/ready hold.
module ula_bus_reader_chk #(
    parameter int NSRC = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NSRC-1:0] en,
    input logic            res_valid,
    input logic            req_ready
);
    // Drivers must never overlap, and nothing drives while a result is held.
    a_en_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(en));
    a_hold_quiet: assert property (@(posedge clk) disable iff (rst)
                                   res_valid |-> (en == '0) && !req_ready);
endmodule

module ula_bus_reader #(
    parameter int WIDTH  = 9,
    parameter int NSRC   = 4,
    parameter int SETTLE = 1,
    parameter int SELW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input logic               clk,
    input logic               rst,
    ula_bus_reader_if.master  bus_if
);
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [NSRC-1:0]  en_q, en_d;
    logic             ready_q, ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-2:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_zero_q, res_zero_d;
    logic             res_err_q, res_err_d;
    logic             accept_s;
    logic             sel_bad_s;

    function automatic logic [NSRC-1:0] sel_onehot(input logic [SELW-1:0] sel);
        logic [NSRC-1:0] oh;
        oh = '0;
        for (int i = 0; i < NSRC; i++) begin
            oh[i] = (sel == SELW'(i));
        end
        return oh;
    endfunction

    function automatic logic data_is_zero(input logic [WIDTH-2:0] data);
        return ~|data;
    endfunction

    assign accept_s  = bus_if.req_valid && ready_q;
    assign sel_bad_s = ({1'b0, bus_if.req_sel} >= (SELW + 1)'(NSRC));

    // Next-state and registered-output decode; en is derived from the next
    // state so it changes only on a clock edge and is one-hot by construction.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sel_bad_s) begin
                        state_d     = ST_HOLD;
                        res_err_d   = 1'b1;
                        res_data_d  = '0;
                        res_carry_d = 1'b0;
                        res_zero_d  = 1'b0;
                    end else begin
                        state_d = ST_TURN;
                        sel_d   = bus_if.req_sel;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                state_d = ST_DRIVE;
                cnt_d   = CNTW'(SETTLE - 1);
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_HOLD;
                    res_data_d  = bus_if.bus[WIDTH-2:0];
                    res_carry_d = bus_if.bus[WIDTH-1];
                    res_zero_d  = data_is_zero(bus_if.bus[WIDTH-2:0]);
                    res_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            ST_HOLD: begin
                if (bus_if.res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DRIVE) begin
            en_d = sel_onehot(sel_d);
        end else begin
            en_d = '0;
        end
        ready_d     = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers; reset forces enables off immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            en_q        <= '0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus_if.req_ready = ready_q;
    assign bus_if.en        = en_q;
    assign bus_if.res_valid = res_valid_q;
    assign bus_if.res_data  = res_data_q;
    assign bus_if.res_carry = res_carry_q;
    assign bus_if.res_zero  = res_zero_q;
    assign bus_if.res_err   = res_err_q;

    ula_bus_reader_chk #(.NSRC(NSRC)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .en        (en_q),
        .res_valid (res_valid_q),
        .req_ready (ready_q)
    );
endmodule

// File: doc/ula_bus_reader.md
# ula_bus_reader

Sequencing reader for the ULA's shared 9-bit tri-state result bus. On request it turns the bus around, enables exactly one tri-state driver, waits a settle interval, and captures the bus value into registered result/flag outputs. The result is then held under a valid/ready handshake. It sits between the ULA control path and the bank of tri-state drivers, as the sole owner of their enable lines.

## Interface
- WIDTH, 9: bus width; bit WIDTH-1 is carry, bits WIDTH-2:0 are data.
- NSRC, 4: number of tri-state drivers on the bus.
- SETTLE, 1: cycles the enable is held before sampling; must be ≥1.
- SELW, $clog2(NSRC): width of the source select.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_sel  in  SELW  driver index to read.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- en  out  NSRC  one-hot driver enables; registered; all-zero when not driving.
- bus  in  WIDTH  shared tri-state bus.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH-1  captured bus[WIDTH-2:0].
- res_carry  out  1  captured bus[WIDTH-1].
- res_zero  out  1  captured data bits all zero.
- res_err  out  1  request had req_sel ≥ NSRC.

## Operation
- States: IDLE, TURN, DRIVE, HOLD.
- IDLE:
  - req_ready=1, en=0.
  - On accept with req_sel<NSRC: latch sel, go to TURN.
  - On accept with req_sel≥NSRC: go to HOLD with res_err=1, res_data=0, res_carry=0, res_zero=0.
- TURN: one cycle with en=0 (bus turnaround; guarantees no two drivers overlap), then go to DRIVE with counter=SETTLE-1.
- DRIVE:
  - en[sel]=1, all other en bits 0.
  - Counter decrements each cycle.
  - On the edge where counter==0: capture bus into res_data/res_carry, set res_zero=(bus[WIDTH-2:0]==0), res_err=0, en→0, go to HOLD.
- HOLD:
  - res_valid=1; result registers stable; en=0; req_ready=0.
  - On the edge with res_ready=1: go to IDLE, res_valid→0. Result registers keep their last value.
- Only one transaction is in flight; new requests are not accepted before returning to IDLE.
- Z/X on the bus is captured as-is; no electrical float detection.
- en is a decoded registered state output; it never glitches and never has more than one bit set.

## Timing
- Reset (async, immediate):
  - state=IDLE, en=0, res_valid=0, res_data=0, res_carry=0, res_zero=0, res_err=0.
  - req_ready=0 while rst is high; 1 from the first cycle after release.
- Reset mid-DRIVE: en drops to 0 asynchronously; no capture occurs.
- Valid read accepted at edge k:
  - TURN during k..k+1.
  - en high from edge k+1 through edge k+1+SETTLE.
  - Capture at edge k+1+SETTLE; res_valid high after that edge.
  - Latency is SETTLE+1 edges (2 for default).
- Invalid read accepted at edge k: res_valid, res_err high after edge k. en never asserts.
- res_ready high continuously: HOLD lasts 1 cycle. Minimum spacing between accepts is SETTLE+3 cycles (valid) or 2 cycles (invalid).
- res_ready already high on HOLD entry: consumed on the next edge.
- res_ready asserted outside HOLD: ignored.
- req_valid dropped before accept: no effect. req_sel is sampled only at accept.

## Test plan
- Reset: assert rst mid-DRIVE with sel=2 → en=0000 immediately, res_valid=0, all result outputs 0; req_ready=1 one cycle after release.
- Basic read: bus model drives 9'h1A5 when en[1]; request sel=1 at edge k → en=0000 during TURN, en=0010 for one cycle, res_valid after edge k+2 with res_data=8'hA5, res_carry=1, res_zero=0.
- Zero flag and back-to-back:
  - sel=3 with bus value 9'h100 → res_data=0, res_carry=1, res_zero=1.
  - Immediately request sel=0 with bus 9'h000 → second result only after the first handshake.
  - en never shows two bits set, and always shows a 0000 cycle between drivers.
- Backpressure: hold res_ready=0 for 5 cycles → res_valid and res_data stable, req_ready=0, en=0000 throughout; releasing → IDLE next edge.
- Invalid select: NSRC=3, req_sel=3 → en stays 0000, res_valid after 1 edge with res_err=1, res_data=0.
- SETTLE=3: en[sel] high exactly 3 cycles. Bus changes value during the first two cycles, final value present in the third → the final value is captured.
